// File: rtl/monitor_estado_pkg.sv
// Shared definitions for the state-code monitor: decoder state codes,
// 7-segment patterns, the monitor FSM state type and small lookup helpers.
package monitor_estado_pkg;

    // State codes emitted by the sequence decoder
    localparam logic [3:0] COD_IDLE  = 4'b0000;
    localparam logic [3:0] COD_P1    = 4'b0001;
    localparam logic [3:0] COD_P2    = 4'b0010;
    localparam logic [3:0] COD_P3    = 4'b0011;
    localparam logic [3:0] COD_P4    = 4'b0100;
    localparam logic [3:0] COD_P5    = 4'b0101;
    localparam logic [3:0] COD_ERRO  = 4'b1000;
    localparam logic [3:0] COD_FIM_A = 4'b1001;
    localparam logic [3:0] COD_FIM_B = 4'b1010;

    // 7-segment patterns, active-high, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    // Monitor state: the class of the most recently registered code
    typedef enum logic [2:0] {
        IDLE,
        TRACK,
        ERRO,
        FIM_A,
        FIM_B,
        INVAL
    } mon_state_e;

    // Map a raw code to its monitor class
    function automatic mon_state_e classify(input logic [3:0] cod);
        mon_state_e cls;
        case (cod)
            COD_IDLE:                                  cls = IDLE;
            COD_P1, COD_P2, COD_P3, COD_P4, COD_P5:    cls = TRACK;
            COD_ERRO:                                  cls = ERRO;
            COD_FIM_A:                                 cls = FIM_A;
            COD_FIM_B:                                 cls = FIM_B;
            default:                                   cls = INVAL;
        endcase
        return cls;
    endfunction

    // Display pattern for a raw code
    function automatic logic [6:0] seg_of(input logic [3:0] cod);
        logic [6:0] pat;
        case (cod)
            COD_IDLE:             pat = SEG_BLANK;
            COD_P1:               pat = SEG_1;
            COD_P2:               pat = SEG_2;
            COD_P3:               pat = SEG_3;
            COD_P4:               pat = SEG_4;
            COD_P5:               pat = SEG_5;
            COD_ERRO:             pat = SEG_E;
            COD_FIM_A, COD_FIM_B: pat = SEG_F;
            default:              pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/monitor_estado_pisca_div.sv
// Blink divider for the error LED: restarts lit with a cleared counter,
// toggles every BLINK_DIV enabled cycles, and idles dark when disabled.
module monitor_estado_pisca_div #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic Reset,
    input  logic restart_i,
    input  logic enable_i,
    output logic led_o
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          led_q;

    // Half-period counter and LED toggle; restart wins over enable
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else if (restart_i) begin
            cnt_q <= '0;
            led_q <= 1'b1;
        end else if (enable_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                led_q <= ~led_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/monitor_estado.sv
// Monitor for the decoder state code: registers the code, classifies it,
// and drives the display digit, status LEDs, completion pulse and step
// counter, all registered (two cycles from estado to outputs).
module monitor_estado
    import monitor_estado_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [3:0]       estado,
    output logic [6:0]       seg,
    output logic             led_erro,
    output logic             led_ok,
    output logic             fim,
    output logic             fim_id,
    output logic [CNT_W-1:0] passos
);

    logic [3:0]       est_q;
    logic [3:0]       prev_cod_q;   // code that produced the current outputs
    mon_state_e       state_q;
    mon_state_e       state_d;
    logic [6:0]       seg_q;
    logic             led_ok_q;
    logic             fim_q;
    logic             fim_id_q;
    logic [CNT_W-1:0] passos_q;
    logic [CNT_W-1:0] passos_d;
    logic             blink_restart;
    logic             blink_enable;

    // Input register: the code is sampled every cycle, no strobe
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            est_q <= COD_IDLE;
        end else begin
            est_q <= estado;
        end
    end

    // Next state is always the class of the registered code; step counter
    // only advances on IDLE->TRACK or TRACK->different TRACK moves
    always_comb begin
        state_d  = classify(est_q);
        passos_d = passos_q;
        if (state_d == TRACK &&
            (state_q == IDLE || (state_q == TRACK && prev_cod_q != est_q))) begin
            if (passos_q != {CNT_W{1'b1}}) begin
                passos_d = passos_q + CNT_W'(1);
            end
        end else if (state_d == IDLE && state_q != IDLE) begin
            passos_d = '0;
        end
    end

    // FSM with registered outputs; entry edges come from state_q vs state_d
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            prev_cod_q <= COD_IDLE;
            seg_q      <= SEG_BLANK;
            led_ok_q   <= 1'b0;
            fim_q      <= 1'b0;
            fim_id_q   <= 1'b0;
            passos_q   <= '0;
        end else begin
            state_q    <= state_d;
            prev_cod_q <= est_q;
            seg_q      <= seg_of(est_q);
            led_ok_q   <= (state_d == FIM_A) || (state_d == FIM_B);
            fim_q      <= ((state_d == FIM_A) || (state_d == FIM_B)) && (state_d != state_q);
            fim_id_q   <= (state_d == FIM_B);
            passos_q   <= passos_d;
        end
    end

    assign blink_restart = (state_d == ERRO) && (state_q != ERRO);
    assign blink_enable  = (state_d == ERRO);

    monitor_estado_pisca_div #(
        .BLINK_DIV (BLINK_DIV)
    ) u_pisca (
        .clk       (clk),
        .Reset     (Reset),
        .restart_i (blink_restart),
        .enable_i  (blink_enable),
        .led_o     (led_erro)
    );

    assign seg    = seg_q;
    assign led_ok = led_ok_q;
    assign fim    = fim_q;
    assign fim_id = fim_id_q;
    assign passos = passos_q;

endmodule

// File: doc/monitor_estado.md
Name: monitor_estado

Overview:
- Downstream consumer of the 4-bit state code produced by the sequence decoder.
- Tracks the code cycle by cycle and classifies it as idle, position 1-5, error, final A (1001), final B (1010) or invalid.
- Drives a 7-segment digit, a blinking error LED, a steady success LED, a one-cycle completion pulse and a saturating step counter.
- Sits between the decoder and the board-level display/LED pins.

Parameters:
- BLINK_DIV, 25_000_000: clk cycles per half-period of the error blink (minimum 2).
- CNT_W, 4: width of the step counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- estado  input  4  state code from the decoder; sampled every rising edge; no valid strobe.
- seg  output  7  7-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
- led_erro  output  1  blinks while in ERRO.
- led_ok  output  1  high while in FIM_A or FIM_B.
- fim  output  1  one-cycle pulse on entry into FIM_A or FIM_B.
- fim_id  output  1  0 = FIM_A, 1 = FIM_B; held while in a final state, else 0.
- passos  output  CNT_W  count of position steps, saturating.

Behaviour:
- Reset (async, active-high) clears everything:
  - state IDLE; est_q = 0000.
  - seg = 0000000; led_erro, led_ok, fim, fim_id = 0.
  - passos = 0; blink counter = 0.
- Input register est_q <= estado every cycle. Classification and all outputs derive from est_q and are registered, so total latency from estado to outputs is 2 cycles.
- FSM states and entry conditions, taken from est_q:
  - IDLE: 0000.
  - TRACK: 0001-0101.
  - ERRO: 1000.
  - FIM_A: 1001.
  - FIM_B: 1010.
  - INVAL: 0110, 0111, 1011-1111.
- Transitions: the next state always equals the class of est_q. The FSM exists to detect entry edges and run the blink and pulse logic, not to filter the input.
- seg by state (registered):
  - IDLE: 0000000.
  - TRACK position 1: 0000110; 2: 1011011; 3: 1001111; 4: 1100110; 5: 1101101.
  - ERRO: 1111001 ("E").
  - FIM_A and FIM_B: 1110001 ("F").
  - INVAL: 1000000 ("-").
- passos:
  - Increments by 1 when est_q enters a TRACK code from IDLE.
  - Increments by 1 when est_q moves from one TRACK code to a different TRACK code.
  - Saturates at 2^CNT_W-1.
  - Cleared to 0 when est_q becomes 0000 from any non-0000 code.
  - Holds in ERRO, FIM and INVAL states.
- led_erro:
  - On ERRO entry the blink counter restarts at 0 and led_erro goes 1 in the same registered update.
  - led_erro toggles every BLINK_DIV cycles while in ERRO.
  - Forced 0 in every other state; the counter is held at 0 outside ERRO.
- led_ok: 1 exactly while in FIM_A or FIM_B.
- fim:
  - High for exactly one cycle on entry into FIM_A or FIM_B from any other state.
  - A direct FIM_A to FIM_B change also pulses.
  - Staying in the same final state does not pulse again.
- fim_id: 0 in FIM_A, 1 in FIM_B, 0 elsewhere.
- Boundary conditions:
  - Same code held for many cycles: no counter change, no pulse.
  - ERRO to TRACK without passing through 0000: leave ERRO, led_erro = 0, passos continues from its held value with no increment for that transition.
  - INVAL is not latched; the next legal code is handled normally.
  - Reset asserted mid-blink or mid-pulse: all outputs go to reset values immediately (asynchronous).
  - Reset deasserting: no spurious fim pulse. IDLE to IDLE is not an entry.

Decomposition:
- Shared package holds:
  - state code constants: COD_IDLE=0000, COD_P1..COD_P5=0001..0101, COD_ERRO=1000, COD_FIM_A=1001, COD_FIM_B=1010.
  - 7-segment pattern constants: SEG_BLANK, SEG_1..SEG_5, SEG_E, SEG_F, SEG_DASH.
  - the monitor state enum: IDLE, TRACK, ERRO, FIM_A, FIM_B, INVAL.
- The decoder and board top reuse the state code constants.
- One sub-module is natural: pisca_div, the blink divider (counter plus toggle, with restart and enable inputs), parameterised by BLINK_DIV.

Test Plan (BLINK_DIV=4, CNT_W=4):
- Reset mid-operation: hold 0011 then assert Reset asynchronously → seg=0000000, passos=0 immediately; after release, estado=0000 → fim never pulses.
- Step counting: estado 0000→0001→0010→0011→0100→0101, each held 3 cycles → seg steps through 0000110, 1011011, 1001111, 1100110, 1101101, each 2 cycles after the input change; passos ends at 5.
- Error blink: from 0010 apply 1000 for 20 cycles → seg=1111001; led_erro=1 for 4 cycles, 0 for 4, 1 for 4, and so on; passos holds at its prior value.
- Completion: 0011→1001 held 10 cycles → fim high exactly 1 cycle, led_ok=1, fim_id=0, seg=1110001; then 1010 → second fim pulse, fim_id=1.
- Saturation and clear: alternate 0001/0010 for 20 changes → passos=15; apply 0000 → passos=0 two cycles later.
- Invalid code: apply 0111 → seg=1000000, led_erro=0, led_ok=0; then 0100 → seg=1100110, no passos increment.
